// File: rtl/serdes_pkg.sv
// Shared serdes definitions: FSM encodings, default word width,
// and the bit-counter width helper.
package serdes_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/deser_bit_counter.sv
// Loadable up-counter for the deserializer bit index.
// tc flags the last data bit (WIDTH-1).
module deser_bit_counter
  import serdes_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic inc,
  output logic tc
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel receiver, MSB first, one-cycle valid pulse.
// Optional even-parity bit when DESER_PARITY_EN is defined.
module deserializer
  import serdes_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
`ifdef DESER_PARITY_EN
  output logic             parity_err,
`endif
  output logic             busy
);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic             tc;

  deser_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == IDLE),
    .inc   (state == SHIFT),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sreg       <= '0;
      data_out   <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
`ifdef DESER_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          sreg <= {sreg[WIDTH-2:0], data_in};
          if (tc) begin
`ifdef DESER_PARITY_EN
            state <= PARITY;
`else
            data_out <= {sreg[WIDTH-2:0], data_in};
            valid    <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
`endif
          end
        end
`ifdef DESER_PARITY_EN
        PARITY: begin
          // word is complete in sreg; data_in is the parity bit
          data_out   <= sreg;
          parity_err <= ^{sreg, data_in};
          valid      <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for deserializer.
// Build with +define+DESER_PARITY_EN to cover the parity frame.
module tb_deserializer;

`ifdef DESER_PARITY_EN
  localparam int FL = 33;
`else
  localparam int FL = 32;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        data_in = 1'b0;
  logic [31:0] data_out;
  logic        valid;
  logic        busy;
`ifdef DESER_PARITY_EN
  logic        parity_err;
`endif

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int bcnt = 0;
  int vcyc[$];
  logic [31:0] vdat[$];

  deserializer #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid      (valid),
`ifdef DESER_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vcyc.push_back(cyc);
      vdat.push_back(data_out);
    end
    if (busy) bcnt <= bcnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    vcyc.delete();
    vdat.delete();
    bcnt = 0;
  endtask

  // en pulse, 32 data bits (optional spurious en), then parity bit
  task automatic drive_frame(input logic [31:0] w, input logic p,
                             input int spur, input logic chk_hold,
                             input logic [31:0] hold, output int e0);
    logic ok;
    ok = 1'b1;
    en = 1'b1;
    tick();
    e0 = cyc;
    for (int i = 0; i < 32; i++) begin
      data_in = w[31-i];
      en = (i == spur);
      if (data_out !== hold) ok = 1'b0;
      tick();
    end
    en = 1'b0;
`ifdef DESER_PARITY_EN
    data_in = p;
    if (data_out !== hold) ok = 1'b0;
    tick();
`else
    if (p) ok = ok;
`endif
    data_in = 1'b0;
    if (chk_hold) begin
      nvec++;
      if (!ok) begin
        nerr++;
        $display("FAIL hold: data_out changed mid-frame, required %h", hold);
      end
    end
  endtask

  task automatic chk_one(input string nm, input logic [31:0] w,
                         input int e0);
    nvec++;
    if (vcyc.size() !== 1) begin
      nerr++;
      $display("FAIL %s_count: got %0d valid pulses, required 1",
               nm, vcyc.size());
    end else begin
      nvec++;
      if (vdat[0] !== w) begin
        nerr++;
        $display("FAIL %s_data: got %h required %h", nm, vdat[0], w);
      end
      nvec++;
      if (vcyc[0] !== e0 + FL) begin
        nerr++;
        $display("FAIL %s_lat: valid at %0d required %0d",
                 nm, vcyc[0] - e0, FL);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_in = ~data_in;
      #5;
    end
    nvec++;
    if ({data_out, valid, busy} !== 34'd0) begin
      nerr++;
      $display("FAIL reset_out: got %h/%b/%b required 0/0/0",
               data_out, valid, busy);
    end
`ifdef DESER_PARITY_EN
    nvec++;
    if (parity_err !== 1'b0) begin
      nerr++;
      $display("FAIL reset_perr: got %b required 0", parity_err);
    end
`endif
    data_in = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_mon();
    tick();
    tick();
    nvec++;
    if (busy !== 1'b0 || vcyc.size() != 0) begin
      nerr++;
      $display("FAIL reset_idle: busy %b pulses %0d required 0 0",
               busy, vcyc.size());
    end
  endtask

  task automatic test_single();
    int e0;
    clear_mon();
    drive_frame(32'hFE12_69FF, 1'b1, -1, 1'b1, 32'h0, e0);
    tick();
    tick();
    chk_one("single", 32'hFE12_69FF, e0);
    nvec++;
    if (bcnt !== FL) begin
      nerr++;
      $display("FAIL single_busy: busy %0d cycles required %0d", bcnt, FL);
    end
    nvec++;
    if (data_out !== 32'hFE12_69FF || valid !== 1'b0) begin
      nerr++;
      $display("FAIL single_hold: got %h/%b required fe1269ff/0",
               data_out, valid);
    end
  endtask

  task automatic test_back_to_back();
    int e0a;
    int e0b;
    clear_mon();
    drive_frame(32'hA5A5_0F0F, 1'b0, -1, 1'b0, 32'h0, e0a);
    nvec++;
    if (valid !== 1'b1) begin
      nerr++;
      $display("FAIL b2b_vcycle: valid %b required 1", valid);
    end
    drive_frame(32'h0000_0001, 1'b1, -1, 1'b1, 32'hA5A5_0F0F, e0b);
    tick();
    tick();
    nvec++;
    if (vcyc.size() !== 2) begin
      nerr++;
      $display("FAIL b2b_count: got %0d pulses required 2", vcyc.size());
    end else begin
      nvec++;
      if (vdat[0] !== 32'hA5A5_0F0F || vdat[1] !== 32'h0000_0001) begin
        nerr++;
        $display("FAIL b2b_data: got %h %h required a5a50f0f 00000001",
                 vdat[0], vdat[1]);
      end
      nvec++;
      if (vcyc[1] - vcyc[0] !== FL + 1) begin
        nerr++;
        $display("FAIL b2b_gap: got %0d required %0d",
                 vcyc[1] - vcyc[0], FL + 1);
      end
    end
  endtask

  task automatic test_spurious_en();
    int e0;
    clear_mon();
    drive_frame(32'h1234_5678, 1'b1, 10, 1'b0, 32'h0, e0);
    for (int i = 0; i < 40; i++) tick();
    chk_one("spur", 32'h1234_5678, e0);
  endtask

  task automatic test_reset_mid();
    int e0;
    logic [31:0] w;
    w = 32'hCAFE_F00D;
    clear_mon();
    en = 1'b1;
    tick();
    en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      data_in = w[31-i];
      tick();
    end
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({data_out, valid, busy} !== 34'd0) begin
      nerr++;
      $display("FAIL midrst_out: got %h/%b/%b required 0/0/0",
               data_out, valid, busy);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    nvec++;
    if (vcyc.size() !== 0) begin
      nerr++;
      $display("FAIL midrst_valid: got %0d pulses required 0", vcyc.size());
    end
    clear_mon();
    drive_frame(32'hDEAD_BEEF, 1'b0, -1, 1'b1, 32'h0, e0);
    tick();
    tick();
    chk_one("midrst_next", 32'hDEAD_BEEF, e0);
  endtask

`ifdef DESER_PARITY_EN
  task automatic test_parity();
    int e0;
    clear_mon();
    drive_frame(32'hFE12_69FF, 1'b1, -1, 1'b0, 32'h0, e0);
    tick();
    chk_one("par_good", 32'hFE12_69FF, e0);
    nvec++;
    if (parity_err !== 1'b0) begin
      nerr++;
      $display("FAIL par_good_err: got %b required 0", parity_err);
    end
    clear_mon();
    drive_frame(32'hFE12_69FF, 1'b0, -1, 1'b0, 32'h0, e0);
    tick();
    chk_one("par_bad", 32'hFE12_69FF, e0);
    nvec++;
    if (parity_err !== 1'b1 || data_out !== 32'hFE12_69FF) begin
      nerr++;
      $display("FAIL par_bad_err: got %b/%h required 1/fe1269ff",
               parity_err, data_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_spurious_en();
    test_reset_mid();
`ifdef DESER_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
